// File: rtl/ram_mem.sv
// ram_mem: single-port byte-addressed word RAM for the playground CPU.
// Registered reads, per-byte write lanes, misaligned accesses flagged.
module ram_mem #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  we,
  input  logic [1:0]            be,
  input  logic                  re,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  rvalid,
  output logic                  err
);

  localparam int IDX_W = $clog2(DEPTH);

  // Zero at time zero; reset deliberately leaves contents alone.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};

  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_d;
  logic                  rvalid_q;
  logic                  rvalid_d;
  logic                  err_q;
  logic                  err_d;

  logic [IDX_W-1:0]      idx;
  logic                  aligned;
  logic                  rd_en;
  logic                  wr_en;
  logic                  wr_lo;
  logic                  wr_hi;
  logic                  misal;

  // Upper word-index bits are dropped so high addresses alias.
  assign idx     = address[IDX_W:1];
  assign aligned = ~address[0];

  // Request qualification and next-state for the output registers.
  always_comb begin
    rd_en    = reset & aligned & re;
    wr_en    = reset & aligned & we;
    wr_lo    = wr_en & be[0];
    wr_hi    = wr_en & be[1];
    misal    = reset & address[0] & (we | re);
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    err_d    = 1'b0;
    if (!reset) begin
      rdata_d = '0;
    end else if (rd_en) begin
      // Array is sampled before the edge's write: read-first.
      rdata_d  = mem_q[idx];
      rvalid_d = 1'b1;
    end else if (misal) begin
      err_d = 1'b1;
    end
  end

  // Byte-lane writes into the storage array.
  always_ff @(posedge clk) begin
    if (wr_lo) begin
      mem_q[idx][7:0] <= wdata[7:0];
    end
    if (wr_hi) begin
      mem_q[idx][15:8] <= wdata[15:8];
    end
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;
  assign err    = err_q;

endmodule

// File: tb/tb_ram_mem.sv
// tb_ram_mem: directed scoreboard bench for ram_mem.
// Expected outputs are queued at drive time and checked after the edge.
module tb_ram_mem;

  localparam int AW    = 16;
  localparam int DW    = 16;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          rvalid;
    logic          err;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] address;
  logic [DW-1:0] wdata;
  logic          we;
  logic [1:0]    be;
  logic          re;
  logic [DW-1:0] rdata;
  logic          rvalid;
  logic          err;

  int vectors = 0;
  int miscompares = 0;

  exp_t          sb_q[$];
  logic [DW-1:0] mdl [DEPTH];
  logic [DW-1:0] mdl_rdata = '0;

  ram_mem #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .DEPTH     (DEPTH)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .address(address),
    .wdata  (wdata),
    .we     (we),
    .be     (be),
    .re     (re),
    .rdata  (rdata),
    .rvalid (rvalid),
    .err    (err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input exp_t e);
    vectors++;
    assert (rdata === e.rdata) else begin
      miscompares++;
      $error("FAIL %s rdata: got %h expected %h", tag, rdata, e.rdata);
    end
    vectors++;
    assert (rvalid === e.rvalid) else begin
      miscompares++;
      $error("FAIL %s rvalid: got %b expected %b", tag, rvalid, e.rvalid);
    end
    vectors++;
    assert (err === e.err) else begin
      miscompares++;
      $error("FAIL %s err: got %b expected %b", tag, err, e.err);
    end
  endtask

  task automatic step(input string tag, input logic rst_n,
                      input logic [AW-1:0] a, input logic [DW-1:0] wd,
                      input logic w, input logic [1:0] b, input logic r);
    exp_t e;
    int   i;
    @(negedge clk);
    reset   = rst_n;
    address = a;
    wdata   = wd;
    we      = w;
    be      = b;
    re      = r;
    i = int'(a[AW-1:1]) % DEPTH;
    e.rvalid = 1'b0;
    e.err    = 1'b0;
    if (!rst_n) begin
      mdl_rdata = '0;
    end else if (a[0] && (w || r)) begin
      e.err = 1'b1;
    end else begin
      if (r) begin
        mdl_rdata = mdl[i];
        e.rvalid  = 1'b1;
      end
      if (w && b[0]) mdl[i][7:0]  = wd[7:0];
      if (w && b[1]) mdl[i][15:8] = wd[15:8];
    end
    e.rdata = mdl_rdata;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      miscompares++;
      $error("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      check(tag, sb_q.pop_front());
    end
  endtask

  task automatic wr(input string tag, input logic [AW-1:0] a,
                    input logic [DW-1:0] d, input logic [1:0] b);
    step(tag, 1'b1, a, d, 1'b1, b, 1'b0);
  endtask

  task automatic rd(input string tag, input logic [AW-1:0] a);
    step(tag, 1'b1, a, '0, 1'b0, 2'b00, 1'b1);
  endtask

  task automatic rd_const(input string tag, input logic [AW-1:0] a,
                          input logic [DW-1:0] want);
    rd(tag, a);
    vectors++;
    assert (rdata === want) else begin
      miscompares++;
      $error("FAIL %s const: got %h expected %h", tag, rdata, want);
    end
  endtask

  initial begin
    for (int k = 0; k < DEPTH; k++) mdl[k] = '0;
    reset = 1'b0; address = '0; wdata = '0;
    we = 1'b0; be = 2'b00; re = 1'b0;

    step("rst0", 1'b0, 16'h0000, '0, 1'b0, 2'b00, 1'b1);
    step("rst1", 1'b0, 16'h0000, '0, 1'b0, 2'b00, 1'b1);

    for (int k = 0; k < 10; k++) wr("clr", 16'(2 * k), 16'h0000, 2'b11);
    step("rst2", 1'b0, 16'h0000, '0, 1'b0, 2'b00, 1'b0);
    for (int k = 0; k < 10; k++) rd_const("stream", 16'(2 * k), 16'h0000);

    wr("wr_beef", 16'h0004, 16'hBEEF, 2'b11);
    rd_const("rd_beef", 16'h0004, 16'hBEEF);

    wr("pre_1234", 16'h0010, 16'h1234, 2'b11);
    wr("wr_hi", 16'h0010, 16'hAB55, 2'b10);
    rd_const("rd_ab34", 16'h0010, 16'hAB34);
    wr("wr_lo", 16'h0010, 16'h00CD, 2'b01);
    rd_const("rd_abcd", 16'h0010, 16'hABCD);

    wr("pre_4242", 16'h0002, 16'h4242, 2'b11);
    wr("mis_wr", 16'h0003, 16'h7777, 2'b11);
    rd_const("rd_4242", 16'h0002, 16'h4242);
    rd("mis_rd", 16'h0005);
    step("idle", 1'b1, 16'h0002, '0, 1'b0, 2'b00, 1'b0);

    wr("wr_5a5a", 16'h0006, 16'h5A5A, 2'b11);
    rd_const("alias", 16'h0806, 16'h5A5A);

    wr("pre_1111", 16'h0020, 16'h1111, 2'b11);
    step("rdw", 1'b1, 16'h0020, 16'h2222, 1'b1, 2'b11, 1'b1);
    vectors++;
    assert (rdata === 16'h1111) else begin
      miscompares++;
      $error("FAIL rdw const: got %h expected %h", rdata, 16'h1111);
    end
    rd_const("rdw_after", 16'h0020, 16'h2222);

    wr("be00", 16'h0004, 16'hFFFF, 2'b00);
    rd_const("be00_rd", 16'h0004, 16'hBEEF);

    step("rst_wr", 1'b0, 16'h0004, 16'h0000, 1'b1, 2'b11, 1'b1);
    rd_const("rst_keep", 16'h0004, 16'hBEEF);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_mem.md
Name: ram_mem

Overview:
Single-port, byte-addressed, word-organised synchronous RAM serving as the main data/instruction store of the playground CPU. It takes a 16-bit byte address that steps by 2 per word, with 16-bit words and per-byte write enables. Reads are registered with one-cycle latency, and misaligned word addresses are flagged as errors.

Parameters:
ADDR_WIDTH, 16, byte-address width.
DATA_WIDTH, 16, word width; fixed at 2 byte lanes.
DEPTH, 1024, number of words stored; must be a power of two, at most 2^(ADDR_WIDTH-1).

Ports:
clk  input  1  system clock; all activity on its rising edge.
reset  input  1  synchronous, active-low reset.
address  input  ADDR_WIDTH  byte address; bit 0 must be 0.
wdata  input  DATA_WIDTH  write data; [7:0] is lane 0, [15:8] is lane 1.
we  input  1  write request.
be  input  2  byte-lane enables for writes.
re  input  1  read request.
rdata  output  DATA_WIDTH  registered read data.
rvalid  output  1  high for one cycle when rdata carries the result of a read.
err  output  1  one-cycle pulse for a rejected (misaligned) access.

Behaviour:
- Synchronous reset: at any rising edge with reset=0:
  - rdata=0, rvalid=0, err=0.
  - Any we/re in that cycle is ignored.
  - Memory contents are not cleared.
- Power-up state: all DEPTH words read as 0 at time zero, via an initial clear. No initial state is required after reset alone.
- Word index: address[ADDR_WIDTH-1:1] modulo DEPTH. Only the low log2(DEPTH) bits of the word index are used, so higher addresses alias (wrap-around) with no error.
- Misaligned access: when address[0]=1 and (we|re)=1:
  - The access is dropped; no memory change.
  - err=1 on the next cycle.
  - rvalid=0 and rdata holds its previous value.
- Write: when we=1, aligned and not in reset:
  - Lane 0 is written from wdata[7:0] if be[0]=1.
  - Lane 1 is written from wdata[15:8] if be[1]=1.
  - be=00 with we=1 is a legal no-op with no error.
- Read: when re=1, aligned and not in reset:
  - The word is sampled at the edge; rdata is updated and rvalid=1 after that edge (one-cycle latency).
  - When re=0, rvalid=0 and rdata holds its last value.
- Simultaneous we and re at the same address: read-first. rdata returns the pre-write contents, and the write takes effect for later reads.
- Back-to-back reads every cycle are sustained at full throughput: address N+2 follows N with no bubbles.
- err and rvalid are never high in the same cycle.
- No handshake or backpressure; every aligned request completes in one cycle.

Test Plan:
- Reset: hold reset=0 for 2 cycles with re=1 at address 0x0000 -> rdata=0x0000, rvalid=0, err=0 throughout.
- Write/readback: write 0xBEEF to 0x0004 with be=11, then read 0x0004 -> next cycle rdata=0xBEEF, rvalid=1.
- Byte lanes: preload 0x1234 at 0x0010; write 0xAB55 with be=10 -> read gives 0xAB34. Then write 0x00CD with be=01 -> read gives 0xABCD.
- Streaming read: clear memory, then read address 0,2,4,...,18 on consecutive cycles from reset release -> rvalid=1 each cycle, all rdata=0x0000, no err.
- Misaligned and aliasing:
  - Write 0x7777 to 0x0003 -> err=1 for one cycle, and a read of 0x0002 still returns its prior value.
  - With DEPTH=1024, write 0x5A5A to 0x0006, then read 0x0806 -> 0x5A5A.
- Read-during-write: 0x0020 holds 0x1111; assert we=1 (0x2222) and re=1 at 0x0020 together -> rdata=0x1111. The following read returns 0x2222.
